// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// baud configuration check used by both UART directions.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } rx_state_t;

   // A usable configuration gives a whole number of clocks per bit, at least four.
   function automatic bit baud_cfg_ok(input longint unsigned br, input longint unsigned clkf);
      if (br == 0 || clkf == 0) return 1'b0;
      if (clkf < 4 * br) return 1'b0;
      return (clkf % br) == 0;
   endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, resetting to RST_VAL.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic stage_p0;
   logic stage_p1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stage_p0 <= RST_VAL;
         stage_p1 <= RST_VAL;
      end else begin
         stage_p0 <= d;
         stage_p1 <= stage_p0;
      end
   end

   assign q = stage_p1;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge re-phasing, mid-bit sampling and a
// single-entry valid/ready holding register with framing/overrun pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned BR   = 0,
   parameter int unsigned CLKF = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int unsigned CLKS_PER_BIT = (BR == 0) ? 1 : CLKF / BR;
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int          CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int          IW           = $clog2(DATA_BITS);

   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'((HALF_BIT > 0) ? HALF_BIT - 1 : 0);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

   if (!baud_cfg_ok(BR, CLKF)) begin : g_bad_cfg
      $fatal(1, "uart_rx: BR=%0d CLKF=%0d is not a usable baud configuration", BR, CLKF);
   end

   logic                 rxs;
   rx_state_t            state;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        idx;
   logic [DATA_BITS-1:0] shreg;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rxs)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shreg     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         if (valid && ready) valid <= 1'b0;

         case (state)
            IDLE: begin
               cnt <= '0;
               if (!rxs) state <= START;
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  // A line that is high again at mid-start was only a glitch.
                  if (!rxs) begin
                     state <= DATA;
                     idx   <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt        <= '0;
                  shreg[idx] <= rxs;
                  if (idx == IDX_LAST) state <= STOP;
                  else idx <= idx + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  if (rxs) begin
                     state <= IDLE;
                     // A same-cycle handshake frees the holding register for the new byte.
                     if (!valid || ready) begin
                        data  <= shreg;
                        valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     frame_err <= 1'b1;
                     state     <= WAIT_IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_IDLE: begin
               cnt <= '0;
               if (rxs) state <= IDLE;
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames for uart_rx at 16 clocks per bit, checked
// against a byte-level model of delivery, framing and overrun.
module tb_uart_rx;

   localparam int unsigned BR   = 100000;
   localparam int unsigned CLKF = 1600000;
   localparam int          CPB  = 16;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic       rx    = 1'b1;
   logic       ready = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       overrun;

   uart_rx #(.BR(BR), .CLKF(CLKF)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .ready     (ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Observed traffic, sampled mid-cycle.
   byte unsigned got_q[$];
   int fe_seen   = 0;
   int ov_seen   = 0;
   int both_seen = 0;

   // Reference model state.
   byte unsigned exp_q[$];
   int           exp_fe = 0;
   int           exp_ov = 0;
   bit           m_full = 1'b0;
   byte unsigned m_byte = 8'h00;

   always @(negedge clk) begin
      if (valid && ready) got_q.push_back(data);
      if (frame_err) fe_seen++;
      if (overrun) ov_seen++;
      if (frame_err && overrun) both_seen++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One frame as seen by the consumer, decided from the line-level rules.
   task automatic model_frame(input byte unsigned b, input bit stop_ok);
      if (!stop_ok) exp_fe++;
      else if (m_full) exp_ov++;
      else if (ready) exp_q.push_back(b);
      else begin
         m_full = 1'b1;
         m_byte = b;
      end
   endtask

   task automatic model_release();
      if (m_full) begin
         exp_q.push_back(m_byte);
         m_full = 1'b0;
      end
   endtask

   task automatic drive(input logic v, input int n);
      rx = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input byte unsigned b, input logic stop);
      drive(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive(b[i], CPB);
      drive(stop, CPB);
   endtask

   task automatic check_stream(input string tag);
      byte unsigned e;
      byte unsigned g;
      check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         check({tag, "_byte"}, 32'(g), 32'(e));
      end
      exp_q.delete();
      got_q.delete();
      check({tag, "_frame_err"}, 32'(fe_seen), 32'(exp_fe));
      check({tag, "_overrun"}, 32'(ov_seen), 32'(exp_ov));
      check({tag, "_both_flags"}, 32'(both_seen), 32'd0);
   endtask

   initial begin
      int           lat;
      byte unsigned b;
      byte unsigned pb;
      int           gap;

      repeat (3) @(posedge clk);
      #1;
      check("rst_data", 32'(data), 32'h0);
      check("rst_valid", 32'(valid), 32'h0);
      check("rst_frame_err", 32'(frame_err), 32'h0);
      check("rst_overrun", 32'(overrun), 32'h0);
      reset = 1'b1;
      drive(1'b1, 10);

      // Single byte with latency measured from the falling start edge.
      lat = 0;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            while (!valid && lat < 300) begin
               @(posedge clk);
               #1;
               lat++;
            end
         end
      join
      model_frame(8'hA5, 1'b1);
      check("t1_latency_in_window", 32'(lat >= 154 && lat <= 156), 32'd1);
      drive(1'b1, 4);
      check_stream("t1");

      // Back-to-back frames without an idle gap.
      send_frame(8'h00, 1'b1);
      model_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      model_frame(8'hFF, 1'b1);
      drive(1'b1, 4);
      check_stream("t2");

      // Short low glitch must not start a frame nor disturb the next one.
      drive(1'b0, 4);
      drive(1'b1, 12);
      check("t3_glitch_valid", 32'(valid), 32'h0);
      b = 8'($urandom);
      send_frame(b, 1'b1);
      model_frame(b, 1'b1);
      drive(1'b1, 4);
      check_stream("t3");

      // Bad stop bit followed by a break, then a good frame.
      send_frame(8'h3C, 1'b0);
      model_frame(8'h3C, 1'b0);
      drive(1'b0, 32);
      drive(1'b1, 20);
      send_frame(8'h81, 1'b1);
      model_frame(8'h81, 1'b1);
      drive(1'b1, 4);
      check_stream("t4");

      // Consumer stalled: second byte is dropped with an overrun pulse.
      ready = 1'b0;
      send_frame(8'h11, 1'b1);
      model_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      model_frame(8'h22, 1'b1);
      drive(1'b1, 4);
      check("t5_valid_held", 32'(valid), 32'h1);
      check("t5_data_held", 32'(data), 32'h11);
      ready = 1'b1;
      @(posedge clk);
      #1;
      ready = 1'b0;
      model_release();
      check("t5_valid_after_accept", 32'(valid), 32'h0);
      drive(1'b1, 40);
      check("t5_valid_stays_low", 32'(valid), 32'h0);
      ready = 1'b1;
      check_stream("t5");

      // Reset in the middle of data bit 4, then a clean frame.
      pb = 8'hC3;
      drive(1'b0, CPB);
      for (int i = 0; i < 4; i++) drive(pb[i], CPB);
      drive(pb[4], 5);
      reset = 1'b0;
      rx    = 1'b1;
      #2;
      check("t6_rst_data", 32'(data), 32'h0);
      check("t6_rst_valid", 32'(valid), 32'h0);
      check("t6_rst_frame_err", 32'(frame_err), 32'h0);
      check("t6_rst_overrun", 32'(overrun), 32'h0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      drive(1'b1, 40);
      check("t6_release_valid", 32'(valid), 32'h0);
      send_frame(8'h5A, 1'b1);
      model_frame(8'h5A, 1'b1);
      drive(1'b1, 4);
      check_stream("t6");

      // Random bytes with random idle gaps.
      for (int k = 0; k < 8; k++) begin
         b   = 8'($urandom);
         gap = $urandom_range(0, 20);
         send_frame(b, 1'b1);
         model_frame(b, 1'b1);
         drive(1'b1, gap);
      end
      drive(1'b1, 4);
      check_stream("rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
